raven_sram_arbiter: RTL and testbench
=====================================

// Module: raven_sram_arbiter
// PURPOSE
//  Shares the single-port 32x1024 SRAM macro (sram_32_1024_freepdk45) between two requesters:
//  m0 = raven_soc core RAM port, m1 = auxiliary master (DMA / debug loader).
//  Issues at most one access per cycle to the macro, with round-robin or fixed priority.
//  Tracks the owner of each read through the macro's fixed read latency.
//  Returns read data with a valid strobe to the requester that issued the read.
//  Sits in raven_wrapper between raven_soc, the aux master and the SRAM macro.
//  It replaces the direct core-to-macro wiring and reset-driven csb0.
// PARAMETERS
//  ADDR_W      10  word address width (1024 words)
//  DATA_W      32  data width
//  RD_LAT      1   macro read latency in pll_clk edges (>=1)
//  PRIO_FIXED  0   0 = round robin; 1 = m0 always wins when both are valid
// PORTS
//  pll_clk     in   1       clock (also drives macro clk0)
//  reset       in   1       synchronous, active-high reset
//  m0_valid    in   1       core request valid
//  m0_we       in   1       1 = write, 0 = read
//  m0_addr     in   ADDR_W  word address
//  m0_wdata    in   DATA_W  write data
//  m0_ready    out  1       request accepted this cycle
//  m0_rvalid   out  1       read data valid for m0
//  m0_rdata    out  DATA_W  read data
//  m1_*        same set as m0_* for the aux requester
//  ram_csb     out  1       macro chip select, active low
//  ram_web     out  1       macro write enable, active low
//  ram_addr    out  ADDR_W  macro address
//  ram_din     out  DATA_W  macro write data
//  ram_dout    in   DATA_W  macro read data
// BEHAVIOUR
//  - Grant is combinational from mX_valid and the last_grant register.
//  - mX_ready = grant_X. A transfer occurs when mX_valid & mX_ready are both high at a rising edge.
//  - Requesters hold valid/we/addr/wdata stable until ready. Requesters may not withdraw valid.
//  - Macro drive follows the grant:
//      granted: ram_csb=0, ram_web=~we, ram_addr/ram_din = winner's fields.
//      no grant: ram_csb=1, ram_web=1, ram_addr/ram_din = 0.
//  - Round robin:
//      only one requester valid -> that requester wins.
//      both valid -> the requester not in last_grant wins.
//      last_grant updates only on a grant.
//      reset value of last_grant = m1, so m0 wins the first contention.
//  - PRIO_FIXED=1: m0 wins whenever m0_valid; last_grant is ignored.
//  - Throughput is one access per cycle, back-to-back, with no bubbles. Worst-case RR wait is 1 cycle.
//  - Read tracking:
//      RD_LAT-deep shift pipe of {vld, owner}.
//      Stage 0 loads {1, id} on a granted read and {0, x} otherwise.
//  - Read response:
//      mX_rvalid = pipe_out.vld & (pipe_out.owner == X).
//      Both mX_rdata = ram_dout (no mux). Contents are meaningful only while rvalid.
//  - Read timing:
//      read granted at edge N -> rvalid high for exactly 1 cycle after edge N+RD_LAT.
//  - Writes produce no response.
//  - No response backpressure: each requester must accept rvalid in that cycle.
//  - Ordering: same-address write then read in consecutive cycles returns the new data (macro write-first).
//  - Reset values: mX_ready=0, mX_rvalid=0, ram_csb=1, ram_web=1, pipe cleared, last_grant=m1.
//      ready/csb are forced inactive while reset is high, regardless of valid.
//  - Reset mid-operation: reads in flight are dropped (no rvalid is ever produced).
//      Writes already sampled by the macro stand.
//  - Simultaneous m0/m1 requests to the same address are serialised by the grant order; no merging.
// STRUCTURE
//  - raven_sram_pkg holds:
//      ADDR_W/DATA_W localparams
//      typedef enum {REQ_M0, REQ_M1} req_id_t
//      struct rd_tag_t {vld, owner}
//  - One sub-module: raven_rr_arb2 (2-way round-robin / fixed arbiter: valid[1:0] -> grant[1:0] onehot0).
//  - Read pipe and macro muxing stay in the top.
// TESTING
//  1. Reset held 3 cycles with m0_valid=m1_valid=1 -> ready=0, ram_csb=1, rvalid=0 every cycle.
//  2. m0 write 0x3FF=0xDEADBEEF, then m0 read 0x3FF
//     -> m0_rvalid one cycle after read grant, m0_rdata=0xDEADBEEF, m1_rvalid=0.
//  3. Both valid continuously for 8 cycles, RR
//     -> grants m0,m1,m0,m1,...; each requester gets 4; ram_csb=0 all cycles.
//  4. PRIO_FIXED=1, m0 valid cycles 0-4, m1 valid cycles 0-6
//     -> m1_ready first at cycle 5; m1 granted cycles 5,6.
//  5. m1 read 0x010 granted, reset asserted the next cycle -> m1_rvalid never asserts; ram_csb=1 during reset.
//  6. Preload [0]=0x11111111, [1]=0x22222222; m0 read 0 and m1 read 1 contending in the same cycles
//     -> m0_rvalid with 0x11111111 then m1_rvalid with 0x22222222, consecutive cycles.
//  7. RD_LAT=2 rebuild of scenario 2 -> rvalid exactly 2 cycles after grant.

Source files
------------

// File: rtl/raven_sram_pkg.sv
// Shared types for the raven SRAM arbiter: bus widths, requester ids and the read-tracking tag.
package raven_sram_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t owner;
    } rd_tag_t;

    // Winner id of a onehot0 grant vector; only meaningful when the grant is non-zero.
    function automatic req_id_t grant_to_id(input logic [1:0] grant);
        return grant[1] ? REQ_M1 : REQ_M0;
    endfunction

endpackage

// File: rtl/raven_rr_arb2.sv
// Two-way arbiter: round robin on last_grant, or m0-wins fixed priority; grant is onehot0.
module raven_rr_arb2
    import raven_sram_pkg::*;
#(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    req_id_t last_grant;

    // Contention goes to the requester that did not win last time (or to m0 when fixed).
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (valid == 2'b11) begin
                if (PRIO_FIXED || (last_grant == REQ_M1)) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end else begin
                grant = valid;
            end
        end
    end

    // Reset to m1 so that m0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_M1;
        end else if (|grant) begin
            last_grant <= grant_to_id(grant);
        end
    end

endmodule

// File: rtl/raven_sram_arbiter.sv
// Shares the single-port 32x1024 SRAM macro between the core (m0) and an aux master (m1),
// issuing one access per cycle and routing each read response back to its issuer.
module raven_sram_arbiter #(
    parameter int unsigned ADDR_W     = raven_sram_pkg::ADDR_W,
    parameter int unsigned DATA_W     = raven_sram_pkg::DATA_W,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned PRIO_FIXED = 0
) (
    input  logic              pll_clk,
    input  logic              reset,

    input  logic              m0_valid,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_valid,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              ram_csb,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    import raven_sram_pkg::*;

    logic [1:0] grant;
    rd_tag_t    rd_in;
    rd_tag_t    rd_pipe [RD_LAT];
    rd_tag_t    rd_out;

    raven_rr_arb2 #(
        .PRIO_FIXED (PRIO_FIXED != 0)
    ) u_arb (
        .clk   (pll_clk),
        .reset (reset),
        .valid ({m1_valid, m0_valid}),
        .grant (grant)
    );

    assign m0_ready = grant[0];
    assign m1_ready = grant[1];

    // Macro drive follows the grant; idle cycles park the bus at zero with the macro deselected.
    always_comb begin
        ram_csb  = 1'b1;
        ram_web  = 1'b1;
        ram_addr = '0;
        ram_din  = '0;
        if (grant[0]) begin
            ram_csb  = 1'b0;
            ram_web  = ~m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (grant[1]) begin
            ram_csb  = 1'b0;
            ram_web  = ~m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    // Tag entering the read pipe this cycle: set only for a granted read.
    always_comb begin
        rd_in = '{vld: 1'b0, owner: REQ_M0};
        if (grant[0] && !m0_we) begin
            rd_in = '{vld: 1'b1, owner: REQ_M0};
        end else if (grant[1] && !m1_we) begin
            rd_in = '{vld: 1'b1, owner: REQ_M1};
        end
    end

    // Owner shift pipe matching the macro read latency; reset drops reads in flight.
    always_ff @(posedge pll_clk) begin
        if (reset) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                rd_pipe[i] <= '{vld: 1'b0, owner: REQ_M0};
            end
        end else begin
            rd_pipe[0] <= rd_in;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rd_out = rd_pipe[RD_LAT-1];

    // Gated by reset so a read landing in a reset cycle never strobes.
    assign m0_rvalid = !reset && rd_out.vld && (rd_out.owner == REQ_M0);
    assign m1_rvalid = !reset && rd_out.vld && (rd_out.owner == REQ_M1);

    assign m0_rdata = ram_dout;
    assign m1_rdata = ram_dout;

endmodule

// File: tb/tb_raven_sram_arbiter.sv
// Bench for raven_sram_arbiter: three instances (RR lat1, fixed lat1, RR lat2) each with a macro model,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_raven_sram_arbiter;

    localparam int NI = 3;

    logic        clk;
    logic        mem_clr;
    logic        rst      [NI];
    logic        rq_v     [NI][2];
    logic        rq_we    [NI][2];
    logic [9:0]  rq_addr  [NI][2];
    logic [31:0] rq_wdata [NI][2];
    logic        rdy      [NI][2];
    logic        rv       [NI][2];
    logic [31:0] rdat     [NI][2];
    logic        ram_csb  [NI];
    logic        ram_web  [NI];
    logic [9:0]  ram_addr [NI];
    logic [31:0] ram_din  [NI];
    logic [31:0] ram_dout [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int unsigned LAT = (k == 2) ? 2 : 1;
        localparam int unsigned PF  = (k == 1) ? 1 : 0;

        raven_sram_arbiter #(
            .ADDR_W     (10),
            .DATA_W     (32),
            .RD_LAT     (LAT),
            .PRIO_FIXED (PF)
        ) u_dut (
            .pll_clk   (clk),
            .reset     (rst[k]),
            .m0_valid  (rq_v[k][0]),
            .m0_we     (rq_we[k][0]),
            .m0_addr   (rq_addr[k][0]),
            .m0_wdata  (rq_wdata[k][0]),
            .m0_ready  (rdy[k][0]),
            .m0_rvalid (rv[k][0]),
            .m0_rdata  (rdat[k][0]),
            .m1_valid  (rq_v[k][1]),
            .m1_we     (rq_we[k][1]),
            .m1_addr   (rq_addr[k][1]),
            .m1_wdata  (rq_wdata[k][1]),
            .m1_ready  (rdy[k][1]),
            .m1_rvalid (rv[k][1]),
            .m1_rdata  (rdat[k][1]),
            .ram_csb   (ram_csb[k]),
            .ram_web   (ram_web[k]),
            .ram_addr  (ram_addr[k]),
            .ram_din   (ram_din[k]),
            .ram_dout  (ram_dout[k])
        );

        // Single-port macro: write at the edge, read data after LAT edges.
        logic [31:0] mem [1024];
        logic [31:0] d1, d2;
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 1024; i++) mem[i] <= '0;
            end else if (!ram_csb[k]) begin
                if (!ram_web[k]) mem[ram_addr[k]] <= ram_din[k];
                else             d1 <= mem[ram_addr[k]];
            end
            d2 <= d1;
        end
        assign ram_dout[k] = (LAT == 1) ? d1 : d2;
    end

    // Reference model state
    int          m_last [NI];
    logic [31:0] m_mem  [NI][1024];
    bit          e_vld  [NI][8];
    int          e_own  [NI][8];
    logic [31:0] e_dat  [NI][8];
    bit          fired  [NI][2];
    bit          o_rdy  [NI][2];
    bit          o_rv   [NI][2];
    logic [31:0] o_rd   [NI][2];
    bit          o_csb  [NI];
    int          n_checks;
    int          n_fail;
    int          cyc;

    function automatic int lat_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    task automatic chk32(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %h required %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int k, input logic act, input logic exp);
        chk32(name, k, 32'(act), 32'(exp));
    endtask

    // Evaluate one cycle of every instance: predict grant, macro drive and responses, then advance the model.
    task automatic model_eval();
        for (int k = 0; k < NI; k++) begin
            int  g;
            int  gi;
            int  slot;
            int  ns;
            bit  has;
            g = -1;
            if (!rst[k]) begin
                if (rq_v[k][0] && rq_v[k][1]) g = (k == 1 || m_last[k] == 1) ? 0 : 1;
                else if (rq_v[k][0])          g = 0;
                else if (rq_v[k][1])          g = 1;
            end
            gi = (g < 0) ? 0 : g;
            for (int m = 0; m < 2; m++) begin
                o_rdy[k][m] = rdy[k][m];
                o_rv[k][m]  = rv[k][m];
                o_rd[k][m]  = rdat[k][m];
            end
            o_csb[k] = ram_csb[k];

            chk1("m0_ready", k, rdy[k][0], g == 0);
            chk1("m1_ready", k, rdy[k][1], g == 1);
            chk1("ram_csb", k, ram_csb[k], g < 0);
            chk1("ram_web", k, ram_web[k], (g < 0) ? 1'b1 : !rq_we[k][gi]);
            chk32("ram_addr", k, 32'(ram_addr[k]), (g < 0) ? 32'd0 : 32'(rq_addr[k][gi]));
            chk32("ram_din", k, ram_din[k], (g < 0) ? 32'd0 : rq_wdata[k][gi]);

            slot = cyc % 8;
            has  = e_vld[k][slot] && !rst[k];
            for (int m = 0; m < 2; m++) begin
                chk1((m == 0) ? "m0_rvalid" : "m1_rvalid", k, rv[k][m], has && e_own[k][slot] == m);
                if (has && e_own[k][slot] == m)
                    chk32((m == 0) ? "m0_rdata" : "m1_rdata", k, rdat[k][m], e_dat[k][slot]);
            end
            e_vld[k][slot] = 1'b0;

            if (rst[k]) begin
                for (int s = 0; s < 8; s++) e_vld[k][s] = 1'b0;
                m_last[k] = 1;
            end else if (g >= 0) begin
                m_last[k]   = g;
                fired[k][g] = 1'b1;
                if (rq_we[k][g]) begin
                    m_mem[k][rq_addr[k][g]] = rq_wdata[k][g];
                end else begin
                    ns = (cyc + lat_of(k)) % 8;
                    e_vld[k][ns] = 1'b1;
                    e_own[k][ns] = g;
                    e_dat[k][ns] = m_mem[k][rq_addr[k][g]];
                end
            end
        end
    endtask

    task automatic step();
        for (int k = 0; k < NI; k++) begin
            fired[k][0] = 1'b0;
            fired[k][1] = 1'b0;
        end
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int k, input int m, input logic v, input logic we,
                           input logic [9:0] addr, input logic [31:0] data);
        rq_v[k][m]     = v;
        rq_we[k][m]    = we;
        rq_addr[k][m]  = addr;
        rq_wdata[k][m] = data;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            rq_v[k][0] = 1'b0;
            rq_v[k][1] = 1'b0;
        end
    endtask

    initial begin
        int n0;
        int n1;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        mem_clr  = 1'b1;
        for (int k = 0; k < NI; k++) begin
            m_last[k] = 1;
            rst[k]    = 1'b1;
            for (int s = 0; s < 8; s++) e_vld[k][s] = 1'b0;
            for (int a = 0; a < 1024; a++) m_mem[k][a] = '0;
            set_req(k, 0, 1'b1, 1'b0, 10'h000, 32'h0);
            set_req(k, 1, 1'b1, 1'b0, 10'h001, 32'h0);
        end

        // Reset held with both requesters valid
        for (int i = 0; i < 3; i++) begin
            step();
            mem_clr = 1'b0;
            chk1("rst_m0_ready", 0, o_rdy[0][0], 1'b0);
            chk1("rst_m1_ready", 0, o_rdy[0][1], 1'b0);
            chk1("rst_csb", 0, o_csb[0], 1'b1);
            chk1("rst_m0_rvalid", 0, o_rv[0][0], 1'b0);
        end
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        idle_all();

        // RR alternation on inst0; fixed priority on inst1
        n0 = 0;
        n1 = 0;
        set_req(0, 0, 1'b1, 1'b1, 10'h100, 32'hA0A0A0A0);
        set_req(0, 1, 1'b1, 1'b1, 10'h101, 32'hB1B1B1B1);
        for (int i = 0; i < 8; i++) begin
            set_req(1, 0, i <= 4, 1'b1, 10'h200, 32'(i));
            set_req(1, 1, i <= 6, 1'b1, 10'h201, 32'(i + 100));
            step();
            chk1("rr_m0_grant", 0, o_rdy[0][0], (i % 2) == 0);
            chk1("rr_m1_grant", 0, o_rdy[0][1], (i % 2) == 1);
            chk1("rr_csb", 0, o_csb[0], 1'b0);
            chk1("fix_m0_ready", 1, o_rdy[1][0], i <= 4);
            chk1("fix_m1_ready", 1, o_rdy[1][1], i == 5 || i == 6);
            n0 += int'(o_rdy[0][0]);
            n1 += int'(o_rdy[0][1]);
        end
        chk32("rr_m0_count", 0, 32'(n0), 32'd4);
        chk32("rr_m1_count", 0, 32'(n1), 32'd4);
        idle_all();

        // Write then read 0x3FF on inst0 (latency 1) and inst2 (latency 2)
        set_req(0, 0, 1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF);
        set_req(2, 0, 1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF);
        step();
        chk1("wr_ready", 0, o_rdy[0][0], 1'b1);
        set_req(0, 0, 1'b1, 1'b0, 10'h3FF, 32'h0);
        set_req(2, 0, 1'b1, 1'b0, 10'h3FF, 32'h0);
        step();
        chk1("rd_ready", 0, o_rdy[0][0], 1'b1);
        chk1("rd_ready", 2, o_rdy[2][0], 1'b1);
        idle_all();
        step();
        chk1("lat1_m0_rvalid", 0, o_rv[0][0], 1'b1);
        chk32("lat1_m0_rdata", 0, o_rd[0][0], 32'hDEADBEEF);
        chk1("lat1_m1_rvalid", 0, o_rv[0][1], 1'b0);
        chk1("lat2_early_rvalid", 2, o_rv[2][0], 1'b0);
        step();
        chk1("lat1_rvalid_drop", 0, o_rv[0][0], 1'b0);
        chk1("lat2_m0_rvalid", 2, o_rv[2][0], 1'b1);
        chk32("lat2_m0_rdata", 2, o_rd[2][0], 32'hDEADBEEF);

        // Preload then contending reads on inst0
        set_req(0, 0, 1'b1, 1'b1, 10'h000, 32'h11111111);
        step();
        idle_all();
        set_req(0, 1, 1'b1, 1'b1, 10'h001, 32'h22222222);
        step();
        set_req(0, 0, 1'b1, 1'b0, 10'h000, 32'h0);
        set_req(0, 1, 1'b1, 1'b0, 10'h001, 32'h0);
        step();
        chk1("cont_m0_first", 0, o_rdy[0][0], 1'b1);
        chk1("cont_m1_wait", 0, o_rdy[0][1], 1'b0);
        rq_v[0][0] = 1'b0;
        step();
        chk1("cont_m1_second", 0, o_rdy[0][1], 1'b1);
        chk1("cont_m0_rvalid", 0, o_rv[0][0], 1'b1);
        chk32("cont_m0_rdata", 0, o_rd[0][0], 32'h11111111);
        idle_all();
        step();
        chk1("cont_m1_rvalid", 0, o_rv[0][1], 1'b1);
        chk32("cont_m1_rdata", 0, o_rd[0][1], 32'h22222222);
        chk1("cont_m0_quiet", 0, o_rv[0][0], 1'b0);

        // Read in flight dropped by reset on inst0 and inst2
        set_req(0, 1, 1'b1, 1'b0, 10'h010, 32'h0);
        set_req(2, 1, 1'b1, 1'b0, 10'h010, 32'h0);
        step();
        chk1("inflight_grant", 0, o_rdy[0][1], 1'b1);
        chk1("inflight_grant", 2, o_rdy[2][1], 1'b1);
        idle_all();
        rst[0] = 1'b1;
        rst[2] = 1'b1;
        step();
        chk1("inflight_rst_rvalid", 0, o_rv[0][1], 1'b0);
        chk1("inflight_rst_csb", 0, o_csb[0], 1'b1);
        chk1("inflight_rst_rvalid", 2, o_rv[2][1], 1'b0);
        rst[0] = 1'b0;
        rst[2] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("inflight_after_rvalid", 0, o_rv[0][1], 1'b0);
            chk1("inflight_after_rvalid", 2, o_rv[2][1], 1'b0);
        end

        // Randomized traffic with occasional resets; requests held until accepted
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < NI; k++) begin
                if (rst[k]) rst[k] = 1'($urandom_range(0, 1));
                else        rst[k] = ($urandom_range(0, 99) < 2);
                for (int m = 0; m < 2; m++) begin
                    if (fired[k][m] || !rq_v[k][m]) begin
                        set_req(k, m, $urandom_range(0, 99) < 65, 1'($urandom_range(0, 1)),
                                10'($urandom_range(0, 15)), $urandom);
                    end
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
